prim_pulse_sync_sched: RTL and testbench

PRIM_PULSE_SYNC_SCHED -- requirements
Module: prim_pulse_sync_sched

---
 rtl/prim_pulse_sync_sched_if.sv | 44 ++++
 rtl/prim_pulse_sync_sched.sv | 175 +++++++++++++++++
 tb/tb_prim_pulse_sync_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/prim_pulse_sync_sched_if.sv
// ---------------------------------------------------------------------------
// prim_pulse_sync_sched_if
// Bundles the event/acknowledge handshake and the status outputs of the pulse
// scheduler. The master side (event source / test environment) drives the
// request and configuration signals. The slave side (the scheduler) drives the
// pulse and status signals.
//
// Signals
//   event_i      single-cycle event request
//   ack_mode_i   1 = wait for ack_i after each issued pulse
//   gap_i        extra spacing cycles after each pulse
//   ack_i        single-cycle acknowledge from the destination domain
//   clr_i        clears the sticky error flags
//   sync_pulse_o single-cycle pulse towards the downstream pulse synchronizer
//   busy_o       scheduler not idle
//   pending_o    events accepted but not yet issued
//   overflow_o   sticky: an event was lost on a saturated counter
//   timeout_o    sticky: an acknowledge did not arrive in time
// ---------------------------------------------------------------------------
interface prim_pulse_sync_sched_if #(
   parameter int CntWidth = 4,
   parameter int GapWidth = 8
);
   logic                event_i;
   logic                ack_mode_i;
   logic [GapWidth-1:0] gap_i;
   logic                ack_i;
   logic                clr_i;
   logic                sync_pulse_o;
   logic                busy_o;
   logic [CntWidth-1:0] pending_o;
   logic                overflow_o;
   logic                timeout_o;

   modport master (
      output event_i, ack_mode_i, gap_i, ack_i, clr_i,
      input  sync_pulse_o, busy_o, pending_o, overflow_o, timeout_o
   );

   modport slave (
      input  event_i, ack_mode_i, gap_i, ack_i, clr_i,
      output sync_pulse_o, busy_o, pending_o, overflow_o, timeout_o
   );
endinterface

// File: rtl/prim_pulse_sync_sched.sv
// ---------------------------------------------------------------------------
// prim_pulse_sync_sched
// Accepts single-cycle events, counts them, and issues them one at a time as
// single-cycle pulses towards a downstream pulse synchronizer. After each
// pulse there are gap_i extra idle cycles. In ack mode the scheduler also
// waits for the destination acknowledge, or for a timeout.
//
// Ports
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   sched  slave modport of prim_pulse_sync_sched_if (requests, config, status)
// ---------------------------------------------------------------------------
module prim_pulse_sync_sched #(
   parameter int CntWidth      = 4,
   parameter int GapWidth      = 8,
   parameter int TimeoutCycles = 256
) (
   input logic                    clk_i,
   input logic                    rst_i,
   prim_pulse_sync_sched_if.slave sched
);

   // The timeout counter only has to reach TimeoutCycles-1.
   localparam int TW = $clog2(TimeoutCycles);

   localparam logic [CntWidth-1:0] CNT_ZERO = {CntWidth{1'b0}};
   localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
   localparam logic [CntWidth-1:0] CNT_MAX  = {CntWidth{1'b1}};
   localparam logic [GapWidth-1:0] GAP_ZERO = {GapWidth{1'b0}};
   localparam logic [GapWidth-1:0] GAP_ONE  = GapWidth'(1);
   localparam logic [TW-1:0]       TO_ZERO  = {TW{1'b0}};
   localparam logic [TW-1:0]       TO_ONE   = TW'(1);
   localparam logic [TW-1:0]       TO_LAST  = TW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GAP      = 2'd3
   } state_e;

   state_e              state_r, state_s;
   logic [CntWidth-1:0] pend_r, pend_s;
   logic [GapWidth-1:0] gap_cnt_r, gap_cnt_s;
   logic [TW-1:0]       to_cnt_r, to_cnt_s;
   logic                ovf_r, ovf_s;
   logic                to_flag_r, to_flag_s;
   logic                pulse_r;
   logic                busy_r;
   logic                dec_s;
   logic                ovf_set_s;
   logic                to_set_s;

   // Next-state logic plus gap/timeout counters. gap_i and ack_mode_i are
   // only looked at in ISSUE, so changes at other times do not affect a pulse
   // cycle that is already under way.
   always_comb begin
      state_s   = state_r;
      gap_cnt_s = gap_cnt_r;
      to_cnt_s  = TO_ZERO;      // zero everywhere but WAIT_ACK, so each entry starts at 0
      to_set_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pend_r != CNT_ZERO) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            gap_cnt_s = sched.gap_i;
            if (sched.ack_mode_i) begin
               state_s = ST_WAIT_ACK;
            end else begin
               state_s = ST_GAP;
            end
         end
         ST_WAIT_ACK: begin
            // An acknowledge on the last permitted cycle beats the timeout.
            if (sched.ack_i) begin
               state_s = ST_GAP;
            end else if (to_cnt_r == TO_LAST) begin
               state_s  = ST_GAP;
               to_set_s = 1'b1;
            end else begin
               state_s  = ST_WAIT_ACK;
               to_cnt_s = to_cnt_r + TO_ONE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_ZERO) begin
               if (pend_r != CNT_ZERO) begin
                  state_s = ST_ISSUE;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s   = ST_GAP;
               gap_cnt_s = gap_cnt_r - GAP_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Pending-event counter. It saturates at its maximum. An event that would
   // overflow the counter is lost and raises the overflow condition.
   always_comb begin
      dec_s     = (state_r == ST_ISSUE);
      pend_s    = pend_r;
      ovf_set_s = 1'b0;
      if (sched.event_i && !dec_s) begin
         if (pend_r == CNT_MAX) begin
            ovf_set_s = 1'b1;
         end else begin
            pend_s = pend_r + CNT_ONE;
         end
      end else if (dec_s && !sched.event_i) begin
         pend_s = pend_r - CNT_ONE;
      end else begin
         pend_s = pend_r;
      end
   end

   // Sticky flags. If a set condition and clr_i arrive together, the set wins.
   always_comb begin
      if (ovf_set_s) begin
         ovf_s = 1'b1;
      end else if (sched.clr_i) begin
         ovf_s = 1'b0;
      end else begin
         ovf_s = ovf_r;
      end
      if (to_set_s) begin
         to_flag_s = 1'b1;
      end else if (sched.clr_i) begin
         to_flag_s = 1'b0;
      end else begin
         to_flag_s = to_flag_r;
      end
   end

   // State, counters and output registers. The pulse and busy registers are
   // loaded from the next state, so they always match the state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         pend_r    <= CNT_ZERO;
         gap_cnt_r <= GAP_ZERO;
         to_cnt_r  <= TO_ZERO;
         ovf_r     <= 1'b0;
         to_flag_r <= 1'b0;
         pulse_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         pend_r    <= pend_s;
         gap_cnt_r <= gap_cnt_s;
         to_cnt_r  <= to_cnt_s;
         ovf_r     <= ovf_s;
         to_flag_r <= to_flag_s;
         pulse_r   <= (state_s == ST_ISSUE);
         busy_r    <= (state_s != ST_IDLE);
      end
   end

   assign sched.sync_pulse_o = pulse_r;
   assign sched.busy_o       = busy_r;
   assign sched.pending_o    = pend_r;
   assign sched.overflow_o   = ovf_r;
   assign sched.timeout_o    = to_flag_r;

endmodule

// File: tb/tb_prim_pulse_sync_sched.sv
// ---------------------------------------------------------------------------
// tb_prim_pulse_sync_sched
// Self-checking bench for prim_pulse_sync_sched. The reference model works
// with whole cycle numbers. It tracks the first cycle in which the scheduler
// may decide to issue again, instead of tracking states. Each predicted pulse
// cycle is pushed into a queue. The monitor pops the queue on every pulse it
// sees and also compares the status outputs in every cycle.
// ---------------------------------------------------------------------------
module tb_prim_pulse_sync_sched;
   localparam int CNT_W   = 4;
   localparam int GAP_W   = 8;
   localparam int TO_CYC  = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prim_pulse_sync_sched_if #(.CntWidth(CNT_W), .GapWidth(GAP_W)) bus ();

   prim_pulse_sync_sched #(
      .CntWidth(CNT_W), .GapWidth(GAP_W), .TimeoutCycles(TO_CYC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .sched(bus.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state (cycle-number based)
   int m_pend       = 0;
   bit m_pulse      = 1'b0;
   int m_free_at    = 0;     // last GAP cycle / first cycle a new issue may be decided
   bit m_wait       = 1'b0;
   int m_wait_start = 0;
   int m_gap        = 0;
   bit m_ovf        = 1'b0;
   bit m_to         = 1'b0;
   int m_last_pulse = -1000;

   int exp_pend    = 0;
   bit exp_busy    = 1'b0;
   bit exp_ovf     = 1'b0;
   bit exp_to      = 1'b0;
   bit model_valid = 1'b0;
   int pulse_q[$];

   // stimulus knobs for the directed scenarios
   bit cur_am   = 1'b0;
   int cur_gap  = 0;
   int ack_dly  = -1;
   int spur_dly = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Drive the inputs for cycle n and advance the model to predict cycle n+1.
   task automatic step(input bit ev, input bit am, input int gap, input bit ack,
                       input bit clr, input bit r);
      int n;
      bit pnext;
      bit ovf_set;
      bit to_set;
      n                = cyc;
      bus.event_i      = ev;
      bus.ack_mode_i   = am;
      bus.gap_i        = GAP_W'(gap);
      bus.ack_i        = ack;
      bus.clr_i        = clr;
      rst              = r;
      if (r) begin
         m_pend    = 0;
         m_pulse   = 1'b0;
         m_free_at = n;
         m_wait    = 1'b0;
         m_ovf     = 1'b0;
         m_to      = 1'b0;
      end else begin
         ovf_set = 1'b0;
         to_set  = 1'b0;
         if (m_pulse) begin
            if (am) begin
               m_wait       = 1'b1;
               m_wait_start = n + 1;
               m_gap        = gap;
            end else begin
               m_free_at = n + gap + 1;
            end
         end else if (m_wait && n >= m_wait_start) begin
            if (ack) begin
               m_wait    = 1'b0;
               m_free_at = n + m_gap + 1;
            end else if (n - m_wait_start == TO_CYC - 1) begin
               m_wait    = 1'b0;
               m_free_at = n + m_gap + 1;
               to_set    = 1'b1;
            end
         end
         pnext = !m_wait && (n >= m_free_at) && (m_pend > 0);
         if (ev && !m_pulse) begin
            if (m_pend == CNT_MAX) ovf_set = 1'b1;
            else m_pend++;
         end else if (!ev && m_pulse) begin
            m_pend--;
         end
         m_ovf   = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_to    = to_set  ? 1'b1 : (clr ? 1'b0 : m_to);
         m_pulse = pnext;
         if (pnext) begin
            pulse_q.push_back(n + 1);
            m_last_pulse = n + 1;
         end
      end
      exp_pend    = m_pend;
      exp_ovf     = m_ovf;
      exp_to      = m_to;
      exp_busy    = r ? 1'b0 : (m_pulse || m_wait || (n + 1 <= m_free_at));
      model_valid = 1'b1;
   endtask

   task automatic cyc_step(input bit ev, input bit clr, input bit r);
      bit ack;
      @(negedge clk);
      ack = (ack_dly >= 0 && cyc == m_last_pulse + ack_dly) ||
            (spur_dly >= 0 && cyc == m_last_pulse + spur_dly);
      step(ev, cur_am, cur_gap, ack, clr, r);
   endtask

   task automatic idle(input int k);
      repeat (k) cyc_step(1'b0, 1'b0, 1'b0);
   endtask

   // monitor: compares status every cycle and consumes expected pulses
   always @(posedge clk) begin
      int dummy;
      #1;
      cyc++;
      if (model_valid) begin
         chk("pending", int'(bus.pending_o), exp_pend);
         chk("busy", int'(bus.busy_o), int'(exp_busy));
         chk("overflow", int'(bus.overflow_o), int'(exp_ovf));
         chk("timeout", int'(bus.timeout_o), int'(exp_to));
         if (bus.sync_pulse_o) begin
            if (pulse_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pulse_unexpected cycle=%0d actual=pulse expected=none", cyc);
            end else begin
               chk("pulse_cycle", cyc, pulse_q.pop_front());
            end
         end else if (pulse_q.size() != 0 && pulse_q[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL pulse_missing cycle=%0d actual=none expected=pulse@%0d", cyc, pulse_q[0]);
            dummy = pulse_q.pop_front();
         end
      end
   end

   initial begin
      int evp;
      bus.event_i    = 1'b0;
      bus.ack_mode_i = 1'b0;
      bus.gap_i      = '0;
      bus.ack_i      = 1'b0;
      bus.clr_i      = 1'b0;

      // reset
      repeat (3) cyc_step(1'b0, 1'b0, 1'b1);
      idle(2);
      // single event, gap 0
      cyc_step(1'b1, 1'b0, 1'b0);
      idle(8);
      // burst of 5, gap 3
      cur_gap = 3;
      repeat (5) cyc_step(1'b1, 1'b0, 1'b0);
      idle(35);
      // 20 back-to-back events, gap 10: saturation and overflow, then clear
      cur_gap = 10;
      repeat (20) cyc_step(1'b1, 1'b0, 1'b0);
      idle(220);
      cyc_step(1'b0, 1'b1, 1'b0);
      idle(3);
      // ack mode: ack 7 cycles after each pulse, spurious ack in GAP
      cur_am = 1'b1; cur_gap = 2; ack_dly = 7; spur_dly = 9;
      repeat (4) cyc_step(1'b1, 1'b0, 1'b0);
      idle(60);
      // ack mode without ack: timeouts
      ack_dly = -1; spur_dly = -1; cur_gap = 1;
      repeat (3) cyc_step(1'b1, 1'b0, 1'b0);
      idle(70);
      cyc_step(1'b0, 1'b1, 1'b0);
      idle(3);
      // reset while waiting for ack with 3 pending
      repeat (4) cyc_step(1'b1, 1'b0, 1'b0);
      idle(5);
      cyc_step(1'b0, 1'b0, 1'b1);
      idle(30);
      // randomized traffic
      evp = 25;
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) evp = $urandom_range(10, 95);
         @(negedge clk);
         step($urandom_range(0, 99) < evp, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(0, 5) == 0,
              $urandom_range(0, 30) == 0, $urandom_range(0, 200) == 0);
      end
      // drain
      cur_am = 1'b0; cur_gap = 0; ack_dly = -1; spur_dly = -1;
      idle(200);
      @(posedge clk);
      #2;
      chk("queue_drained", pulse_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
